// File: rtl/dbus_uncached_axi_slave.sv
// Uncached data-bus responder: turns one held CPU read/write request into a
// single-beat AXI3 transaction and stalls the pipeline until it completes.
module dbus_uncached_axi_slave #(
  parameter int unsigned          BUS_WIDTH = 4,
  parameter logic [BUS_WIDTH-1:0] AXI_ID    = 4'd1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // memory-stage uncached bus
  input  logic                 dbus_read,
  input  logic                 dbus_write,
  input  logic [31:0]          dbus_address,
  input  logic [3:0]           dbus_byteenable,
  input  logic [31:0]          dbus_wrdata,
  output logic [31:0]          dbus_rddata,
  output logic                 dbus_stall,
  output logic                 bus_error,
  // AXI read address / data
  output logic [BUS_WIDTH-1:0] arid,
  output logic [31:0]          araddr,
  output logic [3:0]           arlen,
  output logic [2:0]           arsize,
  output logic [1:0]           arburst,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [31:0]          rdata,
  input  logic [1:0]           rresp,
  input  logic                 rlast,
  input  logic                 rvalid,
  output logic                 rready,
  // AXI write address / data / response
  output logic [BUS_WIDTH-1:0] awid,
  output logic [31:0]          awaddr,
  output logic [3:0]           awlen,
  output logic [2:0]           awsize,
  output logic [1:0]           awburst,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [31:0]          wdata,
  output logic [3:0]           wstrb,
  output logic                 wlast,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic [1:0]           bresp,
  input  logic                 bvalid,
  output logic                 bready
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRdAddr = 3'd1;
  localparam logic [2:0] StRdData = 3'd2;
  localparam logic [2:0] StWr     = 3'd3;
  localparam logic [2:0] StWrResp = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic        wr_pend_q, wr_pend_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] rddata_q, rddata_d;

  logic [2:0]  dec_size;
  logic [1:0]  dec_off;

  // rlast is implied by single-beat reads; low address bits come from the lane decode
  logic unused_sigs;
  assign unused_sigs = ^{dbus_address[1:0], rlast};

  always_comb begin
    dec_size = 3'd2;
    dec_off  = 2'd0;
    case (dbus_byteenable)
      4'b0001: begin dec_size = 3'd0; dec_off = 2'd0; end
      4'b0010: begin dec_size = 3'd0; dec_off = 2'd1; end
      4'b0100: begin dec_size = 3'd0; dec_off = 2'd2; end
      4'b1000: begin dec_size = 3'd0; dec_off = 2'd3; end
      4'b0011: begin dec_size = 3'd1; dec_off = 2'd0; end
      4'b1100: begin dec_size = 3'd1; dec_off = 2'd2; end
      default: begin dec_size = 3'd2; dec_off = 2'd0; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    wr_pend_d = wr_pend_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rddata_d  = rddata_q;
    case (state_q)
      StIdle: begin
        if (dbus_read || dbus_write) begin
          addr_d    = {dbus_address[31:2], dec_off};
          size_d    = dec_size;
          wdata_d   = dbus_wrdata;
          strb_d    = dbus_byteenable;
          wr_pend_d = dbus_read & dbus_write;
          state_d   = dbus_read ? StRdAddr : StWr;
        end
      end
      StRdAddr: if (arready) state_d = StRdData;
      StRdData: begin
        if (rvalid) begin
          rddata_d  = rdata;
          // a paired write follows the read without an intervening DONE
          state_d   = wr_pend_q ? StWr : StDone;
          wr_pend_d = 1'b0;
        end
      end
      StWr: begin
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StWrResp;
        end
      end
      StWrResp: if (bvalid) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      wr_pend_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rddata_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      wr_pend_q <= wr_pend_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rddata_q  <= rddata_d;
    end
  end

  // gated by rst_n so the pipeline is released as soon as reset is asserted
  assign dbus_stall  = rst_n & (dbus_read | dbus_write) & (state_q != StDone);
  assign dbus_rddata = rddata_q;
  assign bus_error   = ((state_q == StRdData) & rvalid & (rresp != 2'b00)) |
                       ((state_q == StWrResp) & bvalid & (bresp != 2'b00));

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 4'd0;
  assign arsize  = size_q;
  assign arburst = 2'b01;
  assign arvalid = (state_q == StRdAddr);
  assign rready  = (state_q == StRdData);

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 4'd0;
  assign awsize  = size_q;
  assign awburst = 2'b01;
  assign awvalid = (state_q == StWr) & ~aw_done_q;
  assign wdata   = wdata_q;
  assign wstrb   = strb_q;
  assign wlast   = 1'b1;
  assign wvalid  = (state_q == StWr) & ~w_done_q;
  assign bready  = (state_q == StWrResp);

endmodule

// File: tb/tb_dbus_uncached_axi_slave.sv
// Directed bench: a cycle-scripted AXI responder drives each request and the
// observed handshakes, stall length and captured fields are compared to hand values.
module tb_dbus_uncached_axi_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dbus_read, dbus_write;
  logic [31:0] dbus_address, dbus_wrdata, dbus_rddata;
  logic [3:0]  dbus_byteenable;
  logic        dbus_stall, bus_error;
  logic [3:0]  arid, awid, arlen, awlen, wstrb;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  dbus_uncached_axi_slave dut (
    .clk(clk), .rst_n(rst_n),
    .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_address(dbus_address),
    .dbus_byteenable(dbus_byteenable), .dbus_wrdata(dbus_wrdata),
    .dbus_rddata(dbus_rddata), .dbus_stall(dbus_stall), .bus_error(bus_error),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // per-transaction observations
  int stall_cyc, ar_hs, r_hs, aw_hs, w_hs, b_hs, err_cyc, err_stray, ar_drop, b_rise;
  int ar_hs_c, aw_first_c, b_hs_c, done_c;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [2:0]  cap_arsize, cap_awsize;
  logic [3:0]  cap_wstrb;
  logic        cap_wlast, txn_done;

  task automatic idle_inputs();
    dbus_read = 1'b0; dbus_write = 1'b0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
  endtask

  // ar/aw/w_lat: cycles a valid waits before ready; r_lat: cycles from AR
  // handshake to rvalid; b_lat: extra cycles after both AW and W completed
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic [31:0] rd_data, input logic [1:0] rr,
                         input logic [1:0] br, input int ar_lat, input int r_lat,
                         input int aw_lat, input int w_lat, input int b_lat);
    int ar_start = -1, aw_start = -1, w_start = -1, aw_hs_c = -1, w_hs_c = -1;
    logic ar_pend = 1'b0, prev_bready = 1'b0;
    stall_cyc = 0; ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
    err_cyc = 0; err_stray = 0; ar_drop = 0; b_rise = 0;
    ar_hs_c = -1; aw_first_c = -1; b_hs_c = -1; done_c = -1; txn_done = 1'b0;
    @(negedge clk);
    dbus_read = rd; dbus_write = wr; dbus_address = addr;
    dbus_byteenable = be; dbus_wrdata = wd;
    for (int c = 0; c < 100 && !txn_done; c++) begin
      if (c > 0) @(negedge clk);
      if (ar_pend && !arvalid) ar_drop++;
      if (arvalid && ar_start < 0) ar_start = c;
      if (awvalid && aw_start < 0) begin aw_start = c; aw_first_c = c; end
      if (wvalid && w_start < 0) w_start = c;
      if (bready && !prev_bready) b_rise++;
      prev_bready = bready;
      arready = arvalid && (c - ar_start >= ar_lat);
      awready = awvalid && (c - aw_start >= aw_lat);
      wready  = wvalid && (c - w_start >= w_lat);
      rvalid  = (ar_hs_c >= 0) && (r_hs == 0) && (c >= ar_hs_c + r_lat);
      rlast   = rvalid;
      rdata   = rvalid ? rd_data : 32'h0;
      rresp   = rr;
      bvalid  = (aw_hs_c >= 0) && (w_hs_c >= 0) && (b_hs == 0) &&
                (c >= ((aw_hs_c > w_hs_c) ? aw_hs_c : w_hs_c) + 1 + b_lat);
      bresp   = br;
      #1;
      if (bus_error) begin
        err_cyc++;
        if (!((rvalid && rready) || (bvalid && bready))) err_stray++;
      end
      if (!dbus_stall) begin done_c = c; txn_done = 1'b1; end
      else stall_cyc++;
      if (arvalid && arready) begin
        ar_hs++; ar_hs_c = c; cap_araddr = araddr; cap_arsize = arsize;
      end
      if (rvalid && rready) r_hs++;
      if (awvalid && awready) begin
        aw_hs++; aw_hs_c = c; cap_awaddr = awaddr; cap_awsize = awsize;
      end
      if (wvalid && wready) begin
        w_hs++; w_hs_c = c; cap_wdata = wdata; cap_wstrb = wstrb; cap_wlast = wlast;
      end
      if (bvalid && bready) begin b_hs++; b_hs_c = c; end
      ar_pend = arvalid && !arready;
    end
    check("txn_completed", txn_done, 1'b1);
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    dbus_address = '0; dbus_byteenable = '0; dbus_wrdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    check("rst_stall", dbus_stall, 1'b0);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_rddata", dbus_rddata, 32'h0);
    check("rst_bus_error", bus_error, 1'b0);
    check("const_ids", {arid, awid}, 8'h11);
    check("const_len_burst", {arlen, awlen, arburst, awburst, wlast}, 13'b0000_0000_01_01_1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // word read, arready two cycles after the request, rvalid 3 cycles after AR
    run_txn(1'b1, 1'b0, 32'h1FD0_F010, 4'b1111, 32'h0, 32'hDEAD_BEEF, 2'b00, 2'b00,
            1, 3, 0, 0, 0);
    check("rd_araddr", cap_araddr, 32'h1FD0_F010);
    check("rd_arsize", cap_arsize, 3'd2);
    check("rd_stall_cycles", stall_cyc, 6);
    check("rd_rddata", dbus_rddata, 32'hDEAD_BEEF);
    check("rd_ar_hs", ar_hs, 1);
    check("rd_r_hs", r_hs, 1);
    check("rd_arvalid_held", ar_drop, 0);
    check("rd_no_aw", aw_hs, 0);

    // byte write to lane 2
    run_txn(1'b0, 1'b1, 32'h1FD0_F000, 4'b0100, 32'h00AB_0000, 32'h0, 2'b00, 2'b00,
            0, 1, 0, 0, 0);
    check("bw_awaddr", cap_awaddr, 32'h1FD0_F002);
    check("bw_awsize", cap_awsize, 3'd0);
    check("bw_wstrb", cap_wstrb, 4'b0100);
    check("bw_wlast", cap_wlast, 1'b1);
    check("bw_wdata", cap_wdata, 32'h00AB_0000);
    check("bw_aw_hs", aw_hs, 1);
    check("bw_w_hs", w_hs, 1);
    check("bw_stall_cycles", stall_cyc, 3);
    check("bw_rddata_kept", dbus_rddata, 32'hDEAD_BEEF);

    // W handshake completes two cycles before AW
    run_txn(1'b0, 1'b1, 32'h1FD0_F020, 4'b1111, 32'h1234_5678, 32'h0, 2'b00, 2'b00,
            0, 1, 2, 0, 1);
    check("wfirst_aw_hs", aw_hs, 1);
    check("wfirst_w_hs", w_hs, 1);
    check("wfirst_resp_once", b_rise, 1);
    check("wfirst_stall_drop", done_c, b_hs_c + 1);
    check("wfirst_stall_cycles", stall_cyc, 6);

    // AW and W in the same cycle
    run_txn(1'b0, 1'b1, 32'h1FD0_F024, 4'b1111, 32'h8765_4321, 32'h0, 2'b00, 2'b00,
            0, 1, 1, 1, 0);
    check("same_aw_hs", aw_hs, 1);
    check("same_w_hs", w_hs, 1);
    check("same_resp_once", b_rise, 1);
    check("same_stall_drop", done_c, b_hs_c + 1);
    check("same_stall_cycles", stall_cyc, 4);

    // simultaneous read and write: read first, single DONE
    run_txn(1'b1, 1'b1, 32'h1FAF_0000, 4'b1111, 32'hA5A5_5A5A, 32'hCAFE_F00D, 2'b00, 2'b00,
            0, 1, 0, 0, 0);
    check("rw_ar_before_aw", (ar_hs_c >= 0) && (ar_hs_c < aw_first_c), 1'b1);
    check("rw_stall_cycles", stall_cyc, 5);
    check("rw_rddata", dbus_rddata, 32'hCAFE_F00D);
    check("rw_awaddr", cap_awaddr, 32'h1FAF_0000);
    check("rw_wdata", cap_wdata, 32'hA5A5_5A5A);
    check("rw_hs_counts", {ar_hs[3:0], r_hs[3:0], aw_hs[3:0], w_hs[3:0], b_hs[3:0]},
          20'h11111);

    // read with SLVERR, half-word lanes 1:0
    run_txn(1'b1, 1'b0, 32'h1FD0_F004, 4'b0011, 32'h0, 32'h0000_BEEF, 2'b10, 2'b00,
            0, 1, 0, 0, 0);
    check("rerr_pulses", err_cyc, 1);
    check("rerr_aligned", err_stray, 0);
    check("rerr_rddata", dbus_rddata, 32'h0000_BEEF);
    check("rerr_arsize", cap_arsize, 3'd1);

    // write with nonzero BRESP, half-word lanes 3:2
    run_txn(1'b0, 1'b1, 32'h1FD0_F008, 4'b1100, 32'h5566_0000, 32'h0, 2'b00, 2'b01,
            0, 1, 0, 0, 0);
    check("berr_pulses", err_cyc, 1);
    check("berr_aligned", err_stray, 0);
    check("berr_awaddr", cap_awaddr, 32'h1FD0_F00A);
    check("berr_awsize", cap_awsize, 3'd1);

    // reset asserted while waiting for read data
    @(negedge clk);
    dbus_read = 1'b1; dbus_address = 32'h1FD0_F010; dbus_byteenable = 4'b1111;
    arready = 1'b1;
    for (int i = 0; i < 10 && !rready; i++) @(negedge clk);
    arready = 1'b0;
    check("rst_mid_in_rd_data", rready, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_arvalid", arvalid, 1'b0);
    check("rst_mid_rready", rready, 1'b0);
    check("rst_mid_stall", dbus_stall, 1'b0);
    check("rst_mid_rddata", dbus_rddata, 32'h0);
    @(negedge clk);
    dbus_read = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    run_txn(1'b1, 1'b0, 32'h1FD0_F00C, 4'b1000, 32'h0, 32'h7700_0000, 2'b00, 2'b00,
            0, 1, 0, 0, 0);
    check("post_rst_araddr", cap_araddr, 32'h1FD0_F00F);
    check("post_rst_arsize", cap_arsize, 3'd0);
    check("post_rst_rddata", dbus_rddata, 32'h7700_0000);
    check("post_rst_stall_cycles", stall_cyc, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
